ra_writer: RTL
==============

Name: ra_writer

Overview:
- Generates the Region Array in VRAM: the tile-by-tile control and list-pointer entries that the region array parser walks at render time.
- Sits between the TA end-of-list logic and the VRAM arbiter, on the same write handshake the parser uses (ra_vram_wr / vram_wait).
- Walks a tile grid row-major and writes one 5-word (fmt v1) or 6-word (fmt v2) entry per tile.
- Each list pointer is derived from a per-list base plus a per-tile OPB stride.

Parameters:
VRAM_ADDR_W, 24, width of the VRAM byte address (16 MB space).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a Region Array build
x_max  in  6  last tile X index (tiles across = x_max+1)
y_max  in  6  last tile Y index (tiles down = y_max+1)
z_keep  in  1  copied to control bit 30 of every entry
REGION_BASE  in  32  byte address of the first entry; only [23:0] used
FPU_PARAM_CFG  in  32  bit 21 = 1 selects fmt v2 (6-word entries)
TA_ALLOC_CTRL  in  32  OPB sizes: o[1:0], om[5:4], t[9:8], tm[13:12], pt[17:16]
ol_base_o  in  24  object-list base, opaque
ol_base_om  in  24  object-list base, opaque modifier
ol_base_t  in  24  object-list base, translucent
ol_base_tm  in  24  object-list base, translucent modifier
ol_base_pt  in  24  object-list base, punch-through
vram_wait  in  1  arbiter stall; a write is accepted on a cycle with ra_vram_wr=1 and vram_wait=0
ra_vram_wr  out  1  write request
ra_vram_addr  out  24  write byte address
ra_vram_dout  out  32  write data
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset values: ra_vram_wr=0, ra_vram_addr=0, ra_vram_dout=0, busy=0, done=0, state=IDLE, tile counters=0.
- IDLE, start=1:
  - latch x_max, y_max, fmt v2 flag and the five OPB sizes;
  - load the five running list pointers from ol_base_*;
  - set addr = REGION_BASE[23:0];
  - go to CTRL; busy=1 next cycle.
- start while busy: ignored.
- Word order per tile: CTRL, OP, OM, TR, TM, then PT only in fmt v2. In fmt v1 the PT state is skipped entirely (no write).
- Each word state:
  - drive ra_vram_wr=1 with addr/dout;
  - hold all three stable while vram_wait=1;
  - on the accept cycle: addr += 4 and advance to the next state.
  - Back-to-back accepts are allowed: one word per cycle when vram_wait stays 0.
- Control word:
  - bit 31 = last, set only when tile_x==x_max and tile_y==y_max;
  - bit 30 = z_keep; bit 28 = 0; bits 13:8 = tile_y; bits 7:2 = tile_x;
  - all other bits 0.
- List word for list k:
  - OPB size 0 gives 0x80000000 (empty);
  - otherwise {8'h00, ptr_k}.
- NEXT state (after the last word of an entry, no write):
  - every enabled ptr_k += 16 << opb_k (32, 64 or 128 bytes), modulo 2^24; disabled pointers are untouched;
  - tile_x += 1; on tile_x==x_max, tile_x=0 and tile_y += 1;
  - if the entry just written was the last tile, go to DONE, else CTRL.
- DONE: ra_vram_wr=0, done=1 for one cycle, busy=0, return to IDLE.
- Address wrap: ra_vram_addr and the list pointers wrap modulo 2^24 with no error.
- Grid size: 1x1 up to 64x64 tiles. A 1x1 grid writes exactly one entry with last=1.
- Reset asserted mid-build: ra_vram_wr drops asynchronously, everything returns to reset values, and no done pulse is produced.
- Latency: for a stall-free build, done is asserted 1 + N*(W+1) cycles after start, where N = number of tiles and W = 5 or 6 words per entry.

Optional Feature:
RA_WRITER_STATS_EN
- Defined: adds output words_written [15:0].
  - Cleared when start is accepted.
  - Incremented on every accepted write.
  - Holds its value after done until the next start.
  - Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. Basic 2x1 grid, fmt v1: REGION_BASE=0x100000, x_max=1, y_max=0, TA_ALLOC_CTRL=0x1, ol_base_o=0x200000, z_keep=0, no stall.
   - Writes at 0x100000..0x100010: 0x00000000, 0x00200000, then 0x80000000 x3.
   - Writes at 0x100014..0x100024: 0x80000004, 0x00200020, then 0x80000000 x3.
   - done pulses once; 10 writes total.
2. Single tile, fmt v2: FPU_PARAM_CFG=0x00200000, x_max=y_max=0, TA_ALLOC_CTRL=0x30000, ol_base_pt=0x300000, z_keep=1.
   - Exactly 6 writes; control=0xC0000000; sixth word=0x00300000 at REGION_BASE+0x14.
3. Stall hold: vram_wait=1 for 5 cycles on the OP word.
   - ra_vram_wr/addr/dout stay constant for all 5 cycles; exactly one accept; sequence otherwise matches scenario 1.
4. Grid wrap: x_max=2, y_max=1, o_opb=3.
   - Control words tile_x/tile_y run (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); only the last has bit 31 set.
   - Opaque pointers step by 128 bytes per tile.
5. Reset mid-build: assert reset during the TR word with vram_wait=1.
   - ra_vram_wr=0 and busy=0 immediately; no done pulse; a new start rebuilds from REGION_BASE.
6. Start while busy: pulse start a second time mid-build.
   - Ignored: write count and sequence match scenario 1 exactly; with RA_WRITER_STATS_EN defined, words_written=10 at done.

Source files
------------

// File: rtl/ra_vram_if.sv
// ra_vram_if: VRAM write handshake between the Region Array writer (master) and the VRAM arbiter (slave).
//   ra_vram_wr   : write request, held until accepted
//   ra_vram_addr : write byte address
//   ra_vram_dout : write data
//   vram_wait    : arbiter stall; a write is accepted when ra_vram_wr=1 and vram_wait=0
interface ra_vram_if #(parameter int AW = 24) ();
    logic          ra_vram_wr;
    logic [AW-1:0] ra_vram_addr;
    logic [31:0]   ra_vram_dout;
    logic          vram_wait;
    modport master (output ra_vram_wr, ra_vram_addr, ra_vram_dout, input vram_wait);
    modport slave  (input ra_vram_wr, ra_vram_addr, ra_vram_dout, output vram_wait);
endinterface

// File: rtl/ra_writer.sv
// ra_writer: builds the Region Array in VRAM, one 5-word (v1) or 6-word (v2) entry per tile, row-major.
//   clock, reset         : system clock, asynchronous active-high reset
//   start                : one-cycle pulse, accepted only when idle
//   x_max, y_max         : last tile indices of the grid
//   z_keep               : copied into control bit 30
//   REGION_BASE          : byte address of the first entry
//   FPU_PARAM_CFG[21]    : selects 6-word entries
//   TA_ALLOC_CTRL        : OPB sizes per list (o, om, t, tm, pt)
//   ol_base_*            : initial list pointers
//   vram                 : VRAM write handshake (master side)
//   busy, done           : build in progress / one-cycle completion pulse
//   Optional macro RA_WRITER_STATS_EN adds words_written[15:0], a count of accepted writes.
module ra_writer #(
    parameter int VRAM_ADDR_W = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [5:0]             x_max,
    input  logic [5:0]             y_max,
    input  logic                   z_keep,
    input  logic [31:0]            REGION_BASE,
    input  logic [31:0]            FPU_PARAM_CFG,
    input  logic [31:0]            TA_ALLOC_CTRL,
    input  logic [VRAM_ADDR_W-1:0] ol_base_o,
    input  logic [VRAM_ADDR_W-1:0] ol_base_om,
    input  logic [VRAM_ADDR_W-1:0] ol_base_t,
    input  logic [VRAM_ADDR_W-1:0] ol_base_tm,
    input  logic [VRAM_ADDR_W-1:0] ol_base_pt,
    ra_vram_if.master              vram,
    output logic                   busy,
    output logic                   done
`ifdef RA_WRITER_STATS_EN
    ,
    output logic [15:0]            words_written
`endif
);
    typedef enum logic [3:0] {IDLE, CTRL, OP, OM, TR, TM, PT, NXT, DONE} state_t;

    state_t                 state_q, word_d;
    logic [5:0]             x_max_q, y_max_q, tx_q, ty_q, tx_d, ty_d;
    logic                   v2_q, last_d;
    logic [1:0]             opb_q [5];
    logic [VRAM_ADDR_W-1:0] ptr_q [5];
    logic [VRAM_ADDR_W-1:0] addr_q;
    logic [31:0]            dout_q, list_d;
    logic                   wr_q, busy_q, done_q;
    logic [2:0]             k_d;
    logic                   unused;

    assign unused = ^{REGION_BASE[31:VRAM_ADDR_W], FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                      TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10],
                      TA_ALLOC_CTRL[7:6], TA_ALLOC_CTRL[3:2]};

    assign vram.ra_vram_wr   = wr_q;
    assign vram.ra_vram_addr = addr_q;
    assign vram.ra_vram_dout = dout_q;
    assign busy              = busy_q;
    assign done              = done_q;

    function automatic logic [31:0] ctrl_word(input logic [5:0] tx, input logic [5:0] ty, input logic last);
        return {last, z_keep, 16'd0, ty, tx, 2'b00};
    endfunction

    // Outputs are registered, so the word for the following state is prepared here.
    always_comb begin
        last_d = (tx_q == x_max_q) && (ty_q == y_max_q);
        tx_d   = (tx_q == x_max_q) ? 6'd0 : tx_q + 6'd1;
        ty_d   = (tx_q == x_max_q) ? ty_q + 6'd1 : ty_q;
        word_d = state_q == CTRL ? OP :
                 state_q == OP   ? OM :
                 state_q == OM   ? TR :
                 state_q == TR   ? TM :
                 (state_q == TM && v2_q) ? PT : NXT;
        k_d    = word_d == OP ? 3'd0 : word_d == OM ? 3'd1 : word_d == TR ? 3'd2 : word_d == TM ? 3'd3 : 3'd4;
        list_d = (opb_q[k_d] == 2'd0) ? 32'h8000_0000 : 32'(ptr_q[k_d]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_max_q <= '0;
            y_max_q <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            v2_q    <= 1'b0;
            opb_q   <= '{default: '0};
            ptr_q   <= '{default: '0};
            addr_q  <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    x_max_q <= x_max;
                    y_max_q <= y_max;
                    v2_q    <= FPU_PARAM_CFG[21];
                    opb_q   <= '{TA_ALLOC_CTRL[1:0], TA_ALLOC_CTRL[5:4], TA_ALLOC_CTRL[9:8],
                                 TA_ALLOC_CTRL[13:12], TA_ALLOC_CTRL[17:16]};
                    ptr_q   <= '{ol_base_o, ol_base_om, ol_base_t, ol_base_tm, ol_base_pt};
                    tx_q    <= '0;
                    ty_q    <= '0;
                    addr_q  <= REGION_BASE[VRAM_ADDR_W-1:0];
                    dout_q  <= ctrl_word(6'd0, 6'd0, (x_max == 6'd0) && (y_max == 6'd0));
                    wr_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= CTRL;
                end
                CTRL, OP, OM, TR, TM, PT: if (!vram.vram_wait) begin
                    addr_q  <= addr_q + VRAM_ADDR_W'(4);
                    wr_q    <= word_d != NXT;
                    dout_q  <= (word_d == NXT) ? dout_q : list_d;
                    state_q <= word_d;
                end
                NXT: begin
                    for (int i = 0; i < 5; i++)
                        if (opb_q[i] != 2'd0) ptr_q[i] <= ptr_q[i] + (VRAM_ADDR_W'(16) << opb_q[i]);
                    tx_q    <= tx_d;
                    ty_q    <= ty_d;
                    dout_q  <= last_d ? dout_q : ctrl_word(tx_d, ty_d, (tx_d == x_max_q) && (ty_d == y_max_q));
                    wr_q    <= !last_d;
                    busy_q  <= !last_d;
                    done_q  <= last_d;
                    state_q <= last_d ? DONE : CTRL;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RA_WRITER_STATS_EN
    logic [15:0] words_q;
    assign words_written = words_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) words_q <= '0;
        else if (state_q == IDLE && start) words_q <= '0;
        else if (wr_q && !vram.vram_wait) words_q <= words_q + 16'd1;
    end
`endif
endmodule
